// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM pipeline stage that sits directly after EX. It runs loads and stores
//   on a req/ack data-memory bus and passes every other instruction's Result
//   straight through to writeback. Byte lanes are big-endian: byte offset 0
//   is bits [31:24]. Byte and half loads are sign- or zero-extended.
//   Upstream is held off with stall while a bus access is open.
//
// Parameters
//   TIMEOUT    BUSY cycles without mem_ack before the access is aborted (1..255)
//
// Ports
//   CLK        clock, all state updates on its rising edge
//   RST        synchronous reset, active-low
//   in_valid   Ins/Result/Rdata2 valid this cycle
//   Ins        instruction; the opcode is Ins[31:26]
//   Result     EX result: ALU value, or effective address for load/store
//   Rdata2     store data (rt)
//   stall      stage busy; upstream holds its inputs
//   wb_valid   one-cycle pulse, Wdata valid
//   Wdata      writeback value (load data or Result)
//   align_err  with wb_valid: misaligned access, no bus cycle was issued
//   bus_err    with wb_valid: the access timed out
//   mem_req    bus request, held until ack or timeout
//   mem_we     bus write enable
//   mem_addr   word address {Result[31:2], 2'b00}
//   mem_be     byte enables, mem_be[3] selects bits [31:24]
//   mem_wdata  store data replicated into the addressed lanes
//   mem_rdata  read data, sampled in the mem_ack cycle
//   mem_ack    access complete; ignored unless a request is open
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] Wdata,
  output logic        align_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // Last BUSY count before the access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  size_t       sz_q, sz_d;
  logic        ld_q, ld_d;
  logic        sgn_q, sgn_d;

  logic        wbv_d, aerr_d, berr_d, req_d, we_d;
  logic [31:0] wdata_d, addr_d, mwd_d;
  logic [3:0]  be_d;

  // Instruction decode
  logic [5:0]  opc;
  logic        is_mem, is_ld, is_sgn, misalign;
  size_t       sz;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic        unused_ins;

  assign opc        = Ins[31:26];
  assign unused_ins = ^Ins[25:0];
  assign stall      = (state_q != IDLE);

  always_comb begin
    is_mem = 1'b0;
    is_ld  = 1'b0;
    is_sgn = 1'b0;
    sz     = SZ_W;
    case (opc)
      OP_LB:   begin is_mem = 1'b1; is_ld = 1'b1; is_sgn = 1'b1; sz = SZ_B; end
      OP_LH:   begin is_mem = 1'b1; is_ld = 1'b1; is_sgn = 1'b1; sz = SZ_H; end
      OP_LW:   begin is_mem = 1'b1; is_ld = 1'b1;                sz = SZ_W; end
      OP_LBU:  begin is_mem = 1'b1; is_ld = 1'b1;                sz = SZ_B; end
      OP_LHU:  begin is_mem = 1'b1; is_ld = 1'b1;                sz = SZ_H; end
      OP_SB:   begin is_mem = 1'b1;                              sz = SZ_B; end
      OP_SH:   begin is_mem = 1'b1;                              sz = SZ_H; end
      OP_SW:   begin is_mem = 1'b1;                              sz = SZ_W; end
      default: begin is_mem = 1'b0; end
    endcase
  end

  assign misalign = ((sz == SZ_W) && (Result[1:0] != 2'b00)) ||
                    ((sz == SZ_H) && Result[0]);

  // Lane enables and replicated store data for the access being accepted
  always_comb begin
    be_c = 4'b1111;
    wd_c = Rdata2;
    case (sz)
      SZ_B: begin
        be_c = 4'b1000 >> Result[1:0];
        wd_c = {4{Rdata2[7:0]}};
      end
      SZ_H: begin
        be_c = Result[1] ? 4'b0011 : 4'b1100;
        wd_c = {2{Rdata2[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = Rdata2;
      end
    endcase
    if (is_ld) wd_c = '0;
  end

  // Lane select and extension of the read data, using the offset captured at accept
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;

  always_comb begin
    case (off_q)
      2'd0:    rd_byte = mem_rdata[31:24];
      2'd1:    rd_byte = mem_rdata[23:16];
      2'd2:    rd_byte = mem_rdata[15:8];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (sz_q)
      SZ_B:    ld_data = {{24{sgn_q & rd_byte[7]}}, rd_byte};
      SZ_H:    ld_data = {{16{sgn_q & rd_half[15]}}, rd_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    sz_d    = sz_q;
    ld_d    = ld_q;
    sgn_d   = sgn_q;
    wbv_d   = 1'b0;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    wdata_d = '0;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    be_d    = mem_be;
    mwd_d   = mem_wdata;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wbv_d   = 1'b1;
            wdata_d = Result;
          end else if (misalign) begin
            wbv_d  = 1'b1;
            aerr_d = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = ~is_ld;
            addr_d  = {Result[31:2], 2'b00};
            be_d    = be_c;
            mwd_d   = wd_c;
            off_d   = Result[1:0];
            sz_d    = sz;
            ld_d    = is_ld;
            sgn_d   = is_sgn;
          end
        end
      end
      BUSY: begin
        // An ack in the expiry cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d = RESP;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          wdata_d = ld_q ? ld_data : '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = RESP;
          req_d   = 1'b0;
          wbv_d   = 1'b1;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      off_q     <= '0;
      sz_q      <= SZ_W;
      ld_q      <= 1'b0;
      sgn_q     <= 1'b0;
      wb_valid  <= 1'b0;
      Wdata     <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      sz_q      <= sz_d;
      ld_q      <= ld_d;
      sgn_q     <= sgn_d;
      wb_valid  <= wbv_d;
      Wdata     <= wdata_d;
      align_err <= aerr_d;
      bus_err   <= berr_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_be    <= be_d;
      mem_wdata <= mwd_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic [31:0] Ins, Result, Rdata2;
  logic        stall, wb_valid, align_err, bus_err;
  logic [31:0] Wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [31:0] ADDU = 32'h0000_0021;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .Ins       (Ins),
    .Result    (Result),
    .Rdata2    (Rdata2),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .Wdata     (Wdata),
    .align_err (align_err),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Aligned access with ack in the first BUSY cycle; checks bus fields and writeback.
  task automatic access(input string tag, input logic [5:0] op, input logic [31:0] res,
                        input logic [31:0] rd2, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_wb);
    Ins = {op, 26'h0}; Result = res; Rdata2 = rd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, ".req"},   32'(mem_req), 32'd1);
    chk({tag, ".stall"}, 32'(stall),   32'd1);
    chk({tag, ".addr"},  mem_addr,     exp_addr);
    chk({tag, ".be"},    32'(mem_be),  32'(exp_be));
    chk({tag, ".we"},    32'(mem_we),  32'(op[3]));
    if (op[3]) chk({tag, ".wdata"}, mem_wdata, exp_wd);
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk({tag, ".resp_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, ".resp_wd"},  Wdata,         exp_wb);
    chk({tag, ".resp_req"}, 32'(mem_req),  32'd0);
    chk({tag, ".resp_stl"}, 32'(stall),    32'd1);
    tick();
    chk({tag, ".idle_stl"}, 32'(stall),    32'd0);
    chk({tag, ".idle_wbv"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    RST = 1'b0; in_valid = 1'b0; Ins = '0; Result = '0; Rdata2 = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst.stall", 32'(stall),    32'd0);
    chk("rst.wbv",   32'(wb_valid), 32'd0);
    chk("rst.req",   32'(mem_req),  32'd0);
    chk("rst.wdata", Wdata,         32'd0);
    chk("rst.addr",  mem_addr,      32'd0);
    chk("rst.be",    32'(mem_be),   32'd0);
    RST = 1'b1;
    tick();

    // 1. ALU passthrough, back-to-back
    Ins = ADDU; Result = 32'h42; in_valid = 1'b1;
    tick();
    chk("addu.wbv",   32'(wb_valid), 32'd1);
    chk("addu.wd",    Wdata,         32'h42);
    chk("addu.req",   32'(mem_req),  32'd0);
    chk("addu.stall", 32'(stall),    32'd0);
    Result = 32'h99;
    tick();
    in_valid = 1'b0;
    chk("addu2.wbv", 32'(wb_valid), 32'd1);
    chk("addu2.wd",  Wdata,         32'h99);
    tick();
    chk("addu.gap", 32'(wb_valid), 32'd0);

    // 2. SB with the ack arriving in the second BUSY cycle
    Ins = {6'h28, 26'h0}; Result = 32'h103; Rdata2 = 32'hAB; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sb.req",   32'(mem_req), 32'd1);
    chk("sb.addr",  mem_addr,     32'h100);
    chk("sb.be",    32'(mem_be),  32'b0001);
    chk("sb.wdata", mem_wdata,    32'hABABABAB);
    chk("sb.we",    32'(mem_we),  32'd1);
    chk("sb.stall", 32'(stall),   32'd1);
    chk("sb.wbv0",  32'(wb_valid), 32'd0);
    tick();
    chk("sb.req2",  32'(mem_req), 32'd1);
    chk("sb.addr2", mem_addr,     32'h100);
    chk("sb.stl2",  32'(stall),   32'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sb.resp_req", 32'(mem_req),  32'd0);
    chk("sb.resp_stl", 32'(stall),    32'd1);
    chk("sb.resp_wbv", 32'(wb_valid), 32'd1);
    chk("sb.resp_wd",  Wdata,         32'd0);
    chk("sb.resp_ber", 32'(bus_err),  32'd0);
    tick();
    chk("sb.end_wbv", 32'(wb_valid), 32'd0);
    chk("sb.end_stl", 32'(stall),    32'd0);

    // 3. Loads with lane select and extension; stores with other widths
    access("lb",  6'h20, 32'h201, 32'h0, 32'h1280FF34, 32'h200, 4'b0100, 32'h0, 32'hFFFFFF80);
    access("lbu", 6'h24, 32'h201, 32'h0, 32'h1280FF34, 32'h200, 4'b0100, 32'h0, 32'h00000080);
    access("lhu", 6'h25, 32'h202, 32'h0, 32'h1280FF34, 32'h200, 4'b0011, 32'h0, 32'h0000FF34);
    access("lh",  6'h21, 32'h200, 32'h0, 32'h80011234, 32'h200, 4'b1100, 32'h0, 32'hFFFF8001);
    access("lb3", 6'h20, 32'h207, 32'h0, 32'hFFFFFF7F, 32'h204, 4'b0001, 32'h0, 32'h0000007F);
    access("lw",  6'h23, 32'h208, 32'h0, 32'hCAFE0123, 32'h208, 4'b1111, 32'h0, 32'hCAFE0123);
    access("sh",  6'h29, 32'h102, 32'h1234ABCD, 32'h0, 32'h100, 4'b0011, 32'hABCDABCD, 32'h0);
    access("sw",  6'h2B, 32'h10C, 32'h89ABCDEF, 32'h0, 32'h10C, 4'b1111, 32'h89ABCDEF, 32'h0);

    // 4. Misaligned accesses
    Ins = {6'h23, 26'h0}; Result = 32'h302; in_valid = 1'b1;
    tick();
    Ins = {6'h21, 26'h0}; Result = 32'h301;
    chk("lw_mis.wbv",  32'(wb_valid),  32'd1);
    chk("lw_mis.aerr", 32'(align_err), 32'd1);
    chk("lw_mis.wd",   Wdata,          32'd0);
    chk("lw_mis.req",  32'(mem_req),   32'd0);
    chk("lw_mis.stl",  32'(stall),     32'd0);
    tick();
    in_valid = 1'b0;
    chk("lh_mis.wbv",  32'(wb_valid),  32'd1);
    chk("lh_mis.aerr", 32'(align_err), 32'd1);
    chk("lh_mis.wd",   Wdata,          32'd0);
    chk("lh_mis.req",  32'(mem_req),   32'd0);
    tick();
    chk("mis.aerr0", 32'(align_err), 32'd0);
    chk("mis.wbv0",  32'(wb_valid),  32'd0);

    // 5a. Timeout: no ack for 4 BUSY cycles
    Ins = {6'h23, 26'h0}; Result = 32'h400; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to.req%0d", i), 32'(mem_req),  32'd1);
      chk($sformatf("to.wbv%0d", i), 32'(wb_valid), 32'd0);
      tick();
    end
    chk("to.resp_req", 32'(mem_req),  32'd0);
    chk("to.resp_wbv", 32'(wb_valid), 32'd1);
    chk("to.resp_ber", 32'(bus_err),  32'd1);
    chk("to.resp_wd",  Wdata,         32'd0);
    chk("to.resp_stl", 32'(stall),    32'd1);
    tick();
    chk("to.end_ber", 32'(bus_err),  32'd0);
    chk("to.end_wbv", 32'(wb_valid), 32'd0);
    chk("to.end_stl", 32'(stall),    32'd0);

    // 5b. Ack in the expiry cycle wins
    Ins = {6'h23, 26'h0}; Result = 32'h404; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("late.req%0d", i), 32'(mem_req), 32'd1);
      tick();
    end
    chk("late.req3", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("late.wbv", 32'(wb_valid), 32'd1);
    chk("late.ber", 32'(bus_err),  32'd0);
    chk("late.wd",  Wdata,         32'hDEADBEEF);
    tick();

    // 6. Reset during BUSY, then a stray ack and a new ALU instruction
    Ins = {6'h23, 26'h0}; Result = 32'h500; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rb.req_pre", 32'(mem_req), 32'd1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("rb.req",   32'(mem_req),  32'd0);
    chk("rb.stall", 32'(stall),    32'd0);
    chk("rb.wbv",   32'(wb_valid), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    Ins = ADDU; Result = 32'h77; in_valid = 1'b1;
    tick();
    mem_ack = 1'b0; in_valid = 1'b0;
    chk("rb.addu_wbv", 32'(wb_valid), 32'd1);
    chk("rb.addu_wd",  Wdata,         32'h77);
    chk("rb.addu_req", 32'(mem_req),  32'd0);
    chk("rb.addu_ber", 32'(bus_err),  32'd0);
    chk("rb.addu_stl", 32'(stall),    32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
